uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
Parametrised UART baud-rate generator, successor to the fixed-table clock divider. Produces an oversampling tick, a mid-bit sample tick and a bit-period tick. Divisors come from an elaboration-time rate table or from a runtime custom divisor. Supports phase re-sync for RX start-bit alignment and glitch-free divisor changes. Feeds both the UART TX and RX engines.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz; used only for the elaboration-time table.
OVERSAMPLE, 16, os_ticks per bit period; must be an even value ≥ 2.
DIV_W, 16, divisor and counter width in bits.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Rst  in  1  synchronous, active-high reset.
Enable  in  1  1 = run; 0 = hold counters and suppress ticks.
Mode  in  1  0 = table divisor from Select; 1 = custom divisor from Div.
Select  in  3  rate index: 0=1200, 1=2400, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
Div  in  DIV_W  custom divisor, used when Mode=1.
Sync  in  1  phase restart pulse, e.g. on an RX start-bit falling edge.
os_tick  out  1  one-cycle pulse every D clocks.
mid_tick  out  1  one-cycle pulse at the centre of each bit.
baud_tick  out  1  one-cycle pulse at the end of each bit.
tiempo  out  DIV_W  active divisor D, for debug readback.

Behaviour:
- Table divisor for a rate B: D = (CLK_HZ + OVERSAMPLE*B/2) / (OVERSAMPLE*B), integer rounded, computed at elaboration. A table entry larger than 2^DIV_W-1 saturates to all-ones.
- Requested divisor R = table[Select] when Mode=0, otherwise Div. R=0 is treated as 1.
- Active divisor D is held in a register. D loads from R only at:
  - reset release,
  - the cycle baud_tick fires,
  - a Sync cycle,
  - any cycle with Enable=0.
  A change of Select/Mode/Div therefore never alters a bit period already in progress.
- Counters:
  - div_cnt, 0..D-1, increments each enabled cycle.
  - os_cnt, 0..OVERSAMPLE-1, increments on each os_tick.
- Ticks (all registered):
  - os_tick = 1 for one cycle when div_cnt wraps (reaches D-1, goes to 0).
  - mid_tick = os_tick AND os_cnt == OVERSAMPLE/2-1.
  - baud_tick = os_tick AND os_cnt == OVERSAMPLE-1. os_cnt wraps to 0 on the same cycle.
- Latency: with D stable and Enable high from cycle 0, the first os_tick appears at cycle D. The first baud_tick appears at cycle D*OVERSAMPLE. The cycle count between consecutive os_ticks is exactly D, including D=1 (os_tick high every cycle).
- Sync, when Enable=1: clears div_cnt and os_cnt and loads D. All ticks are 0 that cycle. The next os_tick follows D cycles later, so mid_tick lands (OVERSAMPLE/2)*D cycles after Sync.
- Sync coincident with a pending wrap: Sync wins, no tick is emitted.
- Sync while Enable=0: ignored apart from the D load.
- Enable=0: counters hold their values and all ticks are 0. Resuming continues from the held count with no extra tick.
- Reset: Rst has priority over everything. Rst=1 forces:
  - div_cnt=0, os_cnt=0,
  - os_tick=0, mid_tick=0, baud_tick=0,
  - D and tiempo = table[3] (9600 baud).
  Reset asserted mid-bit aborts the bit immediately. After Rst deasserts, timing starts fresh per the latency rule above.
- tiempo mirrors the D register and updates on the same cycle D loads.

Test Plan:
- Table rate, 9600: CLK_HZ=50e6, OVERSAMPLE=16, Mode=0, Select=3 → tiempo=326; os_tick every 326 cycles; baud_tick every 5216 cycles; mid_tick 2608 cycles before each baud_tick.
- Table rate, 115200: Select=7 → tiempo=27; baud_tick every 432 cycles. Check 10 consecutive periods exactly.
- Custom divisor: Mode=1, Div=4 → os_tick every 4 cycles, baud_tick every 64 cycles. Div=0 → os_tick every cycle, baud_tick every 16 cycles, tiempo=1.
- Mid-bit divisor change: Mode=1, Div=10. At cycle 50 change Div=20 → current bit still ends at cycle 160 (10*16). The following bit is 320 cycles long and tiempo changes to 20 at cycle 160.
- Sync: Div=10, assert Sync at cycle 73 → no tick at cycle 80; os_tick at 83; mid_tick at 153; baud_tick at 233.
- Enable/reset: deassert Enable for 7 cycles mid-count → every subsequent tick shifts by exactly 7 cycles. Assert Rst mid-bit → all ticks 0 next cycle, tiempo=326, first os_tick 326 cycles after Rst release.

Source files
------------

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Parametrised UART baud-rate generator producing an oversampling tick,
// a mid-bit sample tick and an end-of-bit tick for the UART TX/RX engines.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz, used only to build the rate table
//   OVERSAMPLE os_ticks per bit period (even, >= 2)
//   DIV_W      divisor and counter width
//
// Ports:
//   Clk        system clock, rising edge
//   Rst        synchronous active-high reset
//   Enable     1 = run, 0 = hold counters and suppress ticks
//   Mode       0 = divisor from the rate table via Select, 1 = custom Div
//   Select     rate index 0..7 = 1200,2400,4800,9600,19200,38400,57600,115200
//   Div        custom divisor (0 behaves as 1)
//   Sync       phase restart pulse (e.g. RX start-bit edge)
//   os_tick    one-cycle pulse every D clocks
//   mid_tick   one-cycle pulse at the centre of each bit
//   baud_tick  one-cycle pulse at the end of each bit
//   tiempo     active divisor D for debug readback
module uart_baud_gen #(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Enable,
   input  logic             Mode,
   input  logic [2:0]       Select,
   input  logic [DIV_W-1:0] Div,
   input  logic             Sync,
   output logic             os_tick,
   output logic             mid_tick,
   output logic             baud_tick,
   output logic [DIV_W-1:0] tiempo
);

   localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

   // Rounded divisor for one baud rate, saturating to all-ones when the
   // result does not fit in DIV_W bits.
   function automatic logic [DIV_W-1:0] rate_div(input longint baud);
      longint den;
      longint q;
      longint max_div;
      den     = longint'(OVERSAMPLE) * baud;
      q       = (longint'(CLK_HZ) + den / 2) / den;
      max_div = (longint'(1) << DIV_W) - 1;
      if (q > max_div) begin
         return '1;
      end
      return DIV_W'(q);
   endfunction

   localparam logic [DIV_W-1:0] RATE_TBL [8] = '{
      rate_div(1200),  rate_div(2400),  rate_div(4800),  rate_div(9600),
      rate_div(19200), rate_div(38400), rate_div(57600), rate_div(115200)
   };

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_cnt;
   logic [OS_W-1:0]  os_cnt;
   logic             rst_q;

   logic [DIV_W-1:0] req_raw;
   logic [DIV_W-1:0] req_div;
   logic [DIV_W-1:0] cmp_div;
   logic             load_pre;
   logic             load_div;
   logic             wrap;
   logic             run;
   logic             os_next;
   logic             mid_next;
   logic             baud_next;

   // Requested divisor, wrap detection and next tick values.
   // On any cycle where D is about to reload for a reason other than a bit
   // boundary, the wrap compare already uses the requested divisor, so a
   // freshly loaded D (including D=1) times the very first os period.
   // The bit-boundary reload is kept out of that compare: it is derived
   // from the wrap itself and only takes effect for the following bit.
   // The >= compare also covers a held count that exceeds a smaller new D.
   always_comb begin
      req_raw   = Mode ? Div : RATE_TBL[Select];
      req_div   = (req_raw == '0) ? DIV_W'(1) : req_raw;
      load_pre  = rst_q | Sync | ~Enable;
      cmp_div   = load_pre ? req_div : div_reg;
      wrap      = (div_cnt >= cmp_div - DIV_W'(1));
      run       = Enable & ~Sync;
      os_next   = run & wrap;
      mid_next  = os_next & (os_cnt == OS_MID);
      baud_next = os_next & (os_cnt == OS_LAST);
      load_div  = load_pre | baud_next;
   end

   // Divisor register, counters and registered ticks. Sync clears the
   // phase and suppresses a coincident wrap; Enable=0 freezes the counts.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rst_q     <= 1'b1;
         div_reg   <= RATE_TBL[3];
         div_cnt   <= '0;
         os_cnt    <= '0;
         os_tick   <= 1'b0;
         mid_tick  <= 1'b0;
         baud_tick <= 1'b0;
      end else begin
         rst_q     <= 1'b0;
         os_tick   <= os_next;
         mid_tick  <= mid_next;
         baud_tick <= baud_next;
         if (load_div) begin
            div_reg <= req_div;
         end
         if (Enable && Sync) begin
            div_cnt <= '0;
            os_cnt  <= '0;
         end else if (Enable) begin
            if (wrap) begin
               div_cnt <= '0;
               os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

   assign tiempo = div_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen
// Self-checking bench for uart_baud_gen (CLK_HZ=50 MHz, OVERSAMPLE=16,
// DIV_W=16). Cycle n is the n-th rising edge after the last reset edge
// (cycle 0); inputs set before edge n are sampled at edge n and registered
// outputs are read 1 time unit after edge n. Expected tick cycles are pushed
// into per-tick queues and popped as the DUT pulses.
module tb_uart_baud_gen;

   localparam int OS    = 16;
   localparam int DIV_W = 16;

   logic             Clk;
   logic             Rst;
   logic             Enable;
   logic             Mode;
   logic [2:0]       Select;
   logic [DIV_W-1:0] Div;
   logic             Sync;
   logic             os_tick;
   logic             mid_tick;
   logic             baud_tick;
   logic [DIV_W-1:0] tiempo;

   uart_baud_gen #(
      .CLK_HZ(50000000),
      .OVERSAMPLE(OS),
      .DIV_W(DIV_W)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .Enable(Enable),
      .Mode(Mode),
      .Select(Select),
      .Div(Div),
      .Sync(Sync),
      .os_tick(os_tick),
      .mid_tick(mid_tick),
      .baud_tick(baud_tick),
      .tiempo(tiempo)
   );

   // 10-unit clock period.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic       mode;
      logic [2:0] sel;
      logic [15:0] div;
      int         exp_d;
      int         run_cycles;
   } vec_t;

   vec_t  vecs [11];
   int    cyc;
   int    checks;
   int    errors;
   int    exp_os [$];
   int    exp_mid [$];
   int    exp_baud [$];
   string tick_names [3];

   function automatic int qSize(input int s);
      case (s)
         0:       return exp_os.size();
         1:       return exp_mid.size();
         default: return exp_baud.size();
      endcase
   endfunction

   function automatic int qFront(input int s);
      case (s)
         0:       return exp_os[0];
         1:       return exp_mid[0];
         default: return exp_baud[0];
      endcase
   endfunction

   function automatic int qPop(input int s);
      case (s)
         0:       return exp_os.pop_front();
         1:       return exp_mid.pop_front();
         default: return exp_baud.pop_front();
      endcase
   endfunction

   // Expected ticks of a steady run: os ticks at origin + (k+1)*d, with
   // mid on os index 7 and baud on os index 15 of each bit. Only ticks in
   // (t_min, t_max] are queued.
   task automatic pushPeriodic(input int d, input int origin, input int t_min, input int t_max);
      int t;
      int k;
      k = 0;
      t = origin + d;
      while (t <= t_max) begin
         if (t > t_min) begin
            exp_os.push_back(t);
            if ((k % OS) == OS / 2 - 1) exp_mid.push_back(t);
            if ((k % OS) == OS - 1)     exp_baud.push_back(t);
         end
         k++;
         t = origin + (k + 1) * d;
      end
   endtask

   // Scoreboard compare of the three tick outputs for the current cycle.
   task automatic checkOutput();
      logic [2:0] seen;
      int         exp_t;
      seen = {baud_tick, mid_tick, os_tick};
      for (int s = 0; s < 3; s++) begin
         while (qSize(s) > 0 && qFront(s) < cyc) begin
            exp_t = qPop(s);
            checks++;
            errors++;
            $display("[TB] FAIL %s missing: expected pulse at cycle %0d, still absent at cycle %0d",
                     tick_names[s], exp_t, cyc);
         end
         if (seen[s] === 1'b1) begin
            checks++;
            if (qSize(s) == 0) begin
               errors++;
               $display("[TB] FAIL %s unexpected: pulse at cycle %0d, none required",
                        tick_names[s], cyc);
            end else begin
               exp_t = qPop(s);
               if (exp_t != cyc) begin
                  errors++;
                  $display("[TB] FAIL %s timing: pulse at cycle %0d, required at cycle %0d",
                           tick_names[s], cyc, exp_t);
               end
            end
         end
      end
   endtask

   task automatic checkValue(input string nm, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, actual, required);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic runTo(input int last);
      while (cyc < last) step();
   endtask

   // Every queued tick must have been consumed by the end of a test.
   task automatic flushQueues(input string test);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (qSize(s) != 0) begin
            errors++;
            $display("[TB] FAIL %s leftover in %s: %0d pulses never seen, required 0",
                     tick_names[s], test, qSize(s));
         end
      end
      exp_os.delete();
      exp_mid.delete();
      exp_baud.delete();
   endtask

   // Two reset edges; the second becomes cycle 0 and tiempo must show 326.
   task automatic resetDut();
      Rst = 1'b1;
      step();
      step();
      cyc = 0;
      checkValue("reset tiempo", int'(tiempo), 326);
      Rst = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      Mode   = v.mode;
      Select = v.sel;
      Div    = v.div;
      Enable = 1'b1;
      Sync   = 1'b0;
      resetDut();
   endtask

   initial begin
      tick_names[0] = "os_tick";
      tick_names[1] = "mid_tick";
      tick_names[2] = "baud_tick";
      checks = 0;
      errors = 0;
      cyc    = 0;
      Rst    = 1'b1;
      Enable = 1'b1;
      Mode   = 1'b0;
      Select = 3'd3;
      Div    = '0;
      Sync   = 1'b0;

      // {mode, select, div, expected D, cycles to run}
      vecs = '{
         '{1'b0, 3'd3, 16'd0,  326, 10500},
         '{1'b0, 3'd7, 16'd0,   27,  4400},
         '{1'b0, 3'd0, 16'd0, 2604,  6000},
         '{1'b0, 3'd1, 16'd0, 1302,  3000},
         '{1'b0, 3'd2, 16'd0,  651,  2000},
         '{1'b0, 3'd4, 16'd0,  163,  3000},
         '{1'b0, 3'd5, 16'd0,   81,  1500},
         '{1'b0, 3'd6, 16'd0,   54,  1000},
         '{1'b1, 3'd0, 16'd4,    4,   200},
         '{1'b1, 3'd5, 16'd0,    1,    50},
         '{1'b1, 3'd2, 16'd3,    3,   100}
      };

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
         pushPeriodic(vecs[i].exp_d, 0, 0, vecs[i].run_cycles);
         runTo(vecs[i].run_cycles);
         checkValue("tiempo", int'(tiempo), vecs[i].exp_d);
         flushQueues($sformatf("vector %0d", i));
      end

      // Divisor change mid-bit: current bit keeps D=10, next bit uses 20.
      Mode = 1'b1; Select = 3'd0; Div = 16'd10; Enable = 1'b1; Sync = 1'b0;
      resetDut();
      pushPeriodic(10, 0, 0, 160);
      pushPeriodic(20, 160, 160, 500);
      runTo(49);
      Div = 16'd20;
      runTo(159);
      checkValue("tiempo before bit end", int'(tiempo), 10);
      step();
      checkValue("tiempo at bit end", int'(tiempo), 20);
      runTo(500);
      flushQueues("divisor change");

      // Sync at cycle 73, then Sync on the cycle of a pending wrap (243).
      Div = 16'd10;
      resetDut();
      pushPeriodic(10, 0, 0, 72);
      pushPeriodic(10, 73, 73, 242);
      pushPeriodic(10, 243, 243, 300);
      runTo(72);
      Sync = 1'b1;
      step();
      Sync = 1'b0;
      runTo(242);
      Sync = 1'b1;
      step();
      Sync = 1'b0;
      runTo(300);
      flushQueues("sync");

      // Enable low for cycles 25..31: everything afterwards shifts by 7.
      resetDut();
      pushPeriodic(10, 0, 0, 24);
      pushPeriodic(10, 7, 30, 200);
      runTo(24);
      Enable = 1'b0;
      runTo(31);
      Enable = 1'b1;
      runTo(200);
      flushQueues("enable hold");

      // Reset mid-bit on cycles 95..97, switching to the 9600 table entry.
      resetDut();
      pushPeriodic(10, 0, 0, 94);
      pushPeriodic(326, 97, 97, 1000);
      runTo(94);
      Rst = 1'b1;
      Mode = 1'b0;
      Select = 3'd3;
      step();
      checkValue("tiempo in mid-bit reset", int'(tiempo), 326);
      runTo(97);
      Rst = 1'b0;
      runTo(1000);
      checkValue("tiempo after reset", int'(tiempo), 326);
      flushQueues("mid-bit reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
